// File: rtl/stream_demux.sv
// Registered valid/ready 1-to-N demultiplexer with packet-granular routing.
// Each output channel owns a one-entry register; idle lanes read all ones.
module stream_demux #(
    parameter int DataWidth = 8,
    parameter int Channels  = 8,
    parameter int SelWidth  = 3
) (
    input  logic                          Clk,
    input  logic                          Reset_N,
    input  logic                          Enable,
    input  logic [SelWidth-1:0]           Select,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [DataWidth-1:0]          InData,
    input  logic                          InLast,
    output logic [Channels-1:0]           OValid,
    input  logic [Channels-1:0]           OReady,
    output logic [Channels*DataWidth-1:0] OData,
    output logic [Channels-1:0]           OLast,
    output logic                          Busy,
    output logic                          Dropped
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                         state_q, state_d;
    logic [SelWidth-1:0]            tgt_q, tgt_d;
    logic [Channels-1:0]            ovalid_q, ovalid_d;
    logic [Channels-1:0]            olast_q, olast_d;
    logic [Channels*DataWidth-1:0]  odata_q, odata_d;
    logic                           dropped_q, dropped_d;

    logic [SelWidth-1:0]            tgt;
    logic [Channels-1:0]            hit;
    logic                           sel_ok;
    logic                           tgt_free;
    logic                           discard;
    logic                           accept;
    logic                           load;

    // The locked target is used outside IDLE so a changing Select cannot split a packet.
    always_comb begin
        tgt = (state_q == IDLE) ? Select : tgt_q;
        for (int i = 0; i < Channels; i++) begin
            hit[i] = (tgt == SelWidth'(i));
        end
        sel_ok   = |hit;
        tgt_free = |(hit & (~ovalid_q | OReady));
        discard  = (state_q == DROP) || ((state_q == IDLE) && !sel_ok);

        if (!Reset_N) begin
            InReady = 1'b0;
        end else if (discard) begin
            InReady = Enable;
        end else begin
            InReady = Enable & tgt_free;
        end

        accept = InValid & InReady;
        load   = accept & ~discard;
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        ovalid_d  = ovalid_q;
        olast_d   = olast_q;
        odata_d   = odata_q;
        dropped_d = dropped_q;

        for (int i = 0; i < Channels; i++) begin
            if (load && hit[i]) begin
                ovalid_d[i]                          = 1'b1;
                olast_d[i]                           = InLast;
                odata_d[i*DataWidth +: DataWidth]    = InData;
            end else if (ovalid_q[i] && OReady[i]) begin
                ovalid_d[i]                          = 1'b0;
                olast_d[i]                           = 1'b0;
                odata_d[i*DataWidth +: DataWidth]    = '1;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!sel_ok) begin
                        dropped_d = 1'b1;
                        if (!InLast) state_d = DROP;
                    end else if (!InLast) begin
                        state_d = ROUTE;
                        tgt_d   = Select;
                    end
                end
            end
            ROUTE, DROP: begin
                if (accept && InLast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the output
    // data registers are reset too so lanes read all ones straight out of reset.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            ovalid_q  <= '0;
            olast_q   <= '0;
            odata_q   <= '1;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            ovalid_q  <= ovalid_d;
            olast_q   <= olast_d;
            odata_q   <= odata_d;
            dropped_q <= dropped_d;
        end
    end

    assign OValid  = ovalid_q;
    assign OLast   = olast_q;
    assign OData   = odata_q;
    assign Busy    = (state_q != IDLE);
    assign Dropped = dropped_q;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux with six channels, so Select 6 and 7 are drops.
module tb_stream_demux;

    localparam int DW = 8;
    localparam int CH = 6;
    localparam int SW = 3;

    logic              Clk = 1'b0;
    logic              Reset_N;
    logic              Enable;
    logic [SW-1:0]     Select;
    logic              InValid;
    logic              InReady;
    logic [DW-1:0]     InData;
    logic              InLast;
    logic [CH-1:0]     OValid;
    logic [CH-1:0]     OReady;
    logic [CH*DW-1:0]  OData;
    logic [CH-1:0]     OLast;
    logic              Busy;
    logic              Dropped;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [DW:0] exp_q [CH][$];

    stream_demux #(.DataWidth(DW), .Channels(CH), .SelWidth(SW)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .Enable(Enable), .Select(Select),
        .InValid(InValid), .InReady(InReady), .InData(InData), .InLast(InLast),
        .OValid(OValid), .OReady(OReady), .OData(OData), .OLast(OLast),
        .Busy(Busy), .Dropped(Dropped)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every draining lane must match the head of its queue; idle lanes read FF.
    always @(negedge Clk) begin
        for (int i = 0; i < CH; i++) begin
            logic [DW-1:0] lane;
            lane = OData[i*DW +: DW];
            if (OValid[i] === 1'b1) begin
                if (OReady[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_beat_ch%0d", i), {23'd0, lane, OLast[i]}, 32'hDEAD);
                    end else begin
                        check($sformatf("beat_ch%0d", i), {23'd0, lane, OLast[i]},
                              {23'd0, exp_q[i].pop_front()});
                    end
                end
            end else begin
                check($sformatf("idle_lane_ch%0d", i), {23'd0, lane, OLast[i]}, {23'd0, 8'hFF, 1'b0});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one beat, waits (bounded) for InReady, records the expected output.
    task automatic send_beat(input logic [SW-1:0] sel, input logic [DW-1:0] data,
                             input logic last, input int ch, output int waits);
        Select  = sel;
        InData  = data;
        InLast  = last;
        InValid = 1'b1;
        waits   = 0;
        @(negedge Clk);
        while (InReady !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge Clk);
        end
        if (InReady !== 1'b1) begin
            check("send_timeout", 32'd0, 32'd1);
        end else if (ch >= 0) begin
            exp_q[ch].push_back({data, last});
        end
        tick();
        InValid = 1'b0;
    endtask

    initial begin
        int w;
        int t0;
        Reset_N = 1'b0;
        Enable  = 1'b1;
        Select  = 3'd3;
        InValid = 1'b1;
        InData  = 8'h99;
        InLast  = 1'b1;
        OReady  = '1;

        // Reset with InValid held high
        tick(); tick();
        check("rst_inready", {31'd0, InReady}, 32'd0);
        check("rst_ovalid", {26'd0, OValid}, 32'd0);
        check("rst_olast", {26'd0, OLast}, 32'd0);
        check("rst_odata_lo", OData[31:0], 32'hFFFF_FFFF);
        check("rst_odata_hi", {16'd0, OData[47:32]}, 32'h0000_FFFF);
        check("rst_dropped", {31'd0, Dropped}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        InValid = 1'b0;
        Reset_N = 1'b1;
        tick();

        // Single beat: visible one edge after accept
        send_beat(3'd3, 8'hA5, 1'b1, 3, w);
        check("single_ovalid", {26'd0, OValid}, {26'd0, 6'b001000});
        check("single_lane3", {24'd0, OData[3*DW +: DW]}, 32'h0000_00A5);
        check("single_olast", {26'd0, OLast}, {26'd0, 6'b001000});
        check("single_busy", {31'd0, Busy}, 32'd0);

        // Packet lock: Select changes after first beat but stream stays on 2
        send_beat(3'd2, 8'h11, 1'b0, 2, w);
        check("lock_busy1", {31'd0, Busy}, 32'd1);
        send_beat(3'd5, 8'h22, 1'b0, 2, w);
        check("lock_busy2", {31'd0, Busy}, 32'd1);
        send_beat(3'd5, 8'h33, 1'b0, 2, w);
        check("lock_busy3", {31'd0, Busy}, 32'd1);
        send_beat(3'd5, 8'h44, 1'b1, 2, w);
        check("lock_busy_end", {31'd0, Busy}, 32'd0);
        tick();

        // Backpressure on channel 1
        OReady = 6'b111101;
        send_beat(3'd1, 8'h51, 1'b0, 1, w);
        check("bp_first_wait", w, 32'd0);
        Select  = 3'd1;
        InData  = 8'h52;
        InLast  = 1'b0;
        InValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("bp_inready_low", {31'd0, InReady}, 32'd0);
            check("bp_held_lane1", {23'd0, OData[1*DW +: DW], OValid[1]}, {23'd0, 8'h51, 1'b1});
        end
        tick();
        OReady = '1;
        send_beat(3'd1, 8'h52, 1'b0, 1, w);
        check("bp_release_wait", w, 32'd0);
        send_beat(3'd1, 8'h53, 1'b1, 1, w);
        tick();

        // Back-to-back throughput: three beats in three cycles
        t0 = cyc;
        send_beat(3'd4, 8'hC1, 1'b0, 4, w);
        send_beat(3'd4, 8'hC2, 1'b0, 4, w);
        send_beat(3'd4, 8'hC3, 1'b1, 4, w);
        check("b2b_cycles", cyc - t0, 32'd3);
        tick();

        // Drop: Select 7 with six channels
        check("drop_pre", {31'd0, Dropped}, 32'd0);
        send_beat(3'd7, 8'h71, 1'b0, -1, w);
        check("drop_wait1", w, 32'd0);
        check("drop_flag1", {31'd0, Dropped}, 32'd1);
        check("drop_busy", {31'd0, Busy}, 32'd1);
        send_beat(3'd2, 8'h72, 1'b0, -1, w);
        check("drop_wait2", w, 32'd0);
        send_beat(3'd2, 8'h73, 1'b1, -1, w);
        check("drop_wait3", w, 32'd0);
        check("drop_busy_end", {31'd0, Busy}, 32'd0);
        send_beat(3'd6, 8'h61, 1'b1, -1, w);
        check("drop_sticky", {31'd0, Dropped}, 32'd1);
        tick();

        // Enable low mid-packet holds the lock
        send_beat(3'd3, 8'hE1, 1'b0, 3, w);
        Enable  = 1'b0;
        Select  = 3'd1;
        InData  = 8'hE2;
        InValid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            check("en_inready_low", {31'd0, InReady}, 32'd0);
            check("en_busy_held", {31'd0, Busy}, 32'd1);
        end
        tick();
        Enable = 1'b1;
        send_beat(3'd1, 8'hE2, 1'b0, 3, w);
        send_beat(3'd1, 8'hE3, 1'b1, 3, w);
        tick();

        // Reset mid-packet with a beat stuck in channel 4
        OReady = 6'b101111;
        send_beat(3'd4, 8'hD1, 1'b0, 4, w);
        check("rstmid_busy", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < CH; i++) exp_q[i].delete();
        Reset_N = 1'b0;
        tick();
        Reset_N = 1'b1;
        OReady  = '1;
        check("rstmid_ovalid", {26'd0, OValid}, 32'd0);
        check("rstmid_busy_clr", {31'd0, Busy}, 32'd0);
        check("rstmid_dropped_clr", {31'd0, Dropped}, 32'd0);
        send_beat(3'd0, 8'h0F, 1'b1, 0, w);
        check("rstmid_fresh_ovalid", {26'd0, OValid}, {26'd0, 6'b000001});
        tick(); tick();

        for (int i = 0; i < CH; i++) begin
            check($sformatf("queue_empty_ch%0d", i), exp_q[i].size(), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Registered, handshaked 1-to-N demultiplexer with valid/ready flow control, packet-granular routing and per-channel output buffering. It is the parametrised successor of the A09 combinational Demux and generalises channel count and width. It steers beats from one producer (bus/fetch path) to one of N consumers (Register-File write ports, peripheral sinks). An inactive lane drives all-ones, the same idle convention as the combinational Demux.

Parameters:
DataWidth, 8, bits per beat.
Channels, 8, number of output channels (2..16).
SelWidth, 3, width of Select; must satisfy 2**SelWidth >= Channels.

Ports:
Clk  input  1  rising-edge clock.
Reset_N  input  1  synchronous, active-low reset.
Enable  input  1  accepts new beats when high; output drain continues while low.
Select  input  SelWidth  destination channel; sampled only on the first beat of a packet.
InValid  input  1  producer beat valid.
InReady  output  1  block accepts a beat this cycle (combinational).
InData  input  DataWidth  beat data.
InLast  input  1  final beat of a packet.
OValid  output  Channels  per-channel beat valid.
OReady  input  Channels  per-channel consumer ready.
OData  output  Channels*DataWidth  channel i occupies bits [i*DataWidth +: DataWidth].
OLast  output  Channels  per-channel last flag.
Busy  output  1  a packet lock is held (state is not IDLE).
Dropped  output  1  sticky flag: a packet was addressed to Select >= Channels.

Behaviour:
- Accept = InValid & InReady.
- Reset_N low at a Clk edge gives: state IDLE; OValid = 0; OLast = 0; OData lanes all ones; Dropped = 0. While Reset_N is low, InReady = 0.
- Reset mid-packet abandons the lock and discards buffered beats with no partial output.
- Each channel has a one-entry output register: full when OValid[i]=1. It drains on OValid[i] & OReady[i].
- After draining, the lane returns to all-ones, OLast[i]=0.
- Latency: a beat accepted at edge N appears on OValid/OData at edge N+1.
- Throughput: one beat per clock, since a full register draining this cycle may be reloaded in the same cycle.
- FSM states:
  - IDLE: Tgt = Select.
    - Select < Channels: InReady = Enable & (~OValid[Tgt] | OReady[Tgt]). On accept, the beat is loaded into Tgt. If InLast=0, go to ROUTE with Tgt locked; if InLast=1, stay IDLE (single-beat packet).
    - Select >= Channels: InReady = Enable. On accept the beat is discarded and Dropped set to 1. If InLast=0, go to DROP.
  - ROUTE: Select ignored; InReady = Enable & (~OValid[Tgt] | OReady[Tgt]). On accept, load into Tgt; an accepted InLast returns to IDLE.
  - DROP: InReady = Enable; beats are discarded; an accepted InLast returns to IDLE.
- Busy = (state != IDLE).
- Only the target channel's register is written; other channels continue draining independently.
- Enable low: no accept, lock and state held, outputs drain normally.
- InReady must not depend on InValid; the producer may hold InValid and is never required to drop it.
- Dropped clears only on reset.

Test Plan:
- Reset: hold Reset_N=0 for 2 cycles with InValid=1 -> InReady=0, OValid=0, all OData lanes = 8'hFF, Dropped=0, Busy=0.
- Single beat: Select=3, InData=8'hA5, InLast=1, OReady=all 1 -> OValid=8'b0000_1000 one cycle later, lane 3 = A5, OLast[3]=1, other lanes FF, Busy stays 0.
- Packet lock: 4-beat packet 11,22,33,44 with Select=2, Select changed to 5 after beat 1 -> all four beats exit on channel 2 in order, OLast[2] only on 44, Busy=1 during beats 1..3.
- Backpressure: OReady[1]=0, stream 3 beats to channel 1 -> first beat held in register, InReady=0 until OReady[1]=1, no loss or duplication. Back-to-back beats at 1/clock when ready.
- Drop: Channels=6, Select=7, 3-beat packet -> InReady=1 throughout, no OValid asserted, Dropped=1 after first beat and stays 1.
- Enable/reset mid-packet: Enable=0 during beat 2 -> InReady=0, lock held, resumes on channel. Reset_N=0 mid-packet -> IDLE, buffers empty, next packet routes by fresh Select.
